// File: rtl/pc_pkg.sv
// ----------------------------------------------------------------------------
// pc_pkg
//   Shared definitions for the fetch-PC sequencer: the branch condition code
//   encoding, the bit positions of the {N,V,Z} flag vector, and the condition
//   evaluator used by the next-PC logic.
// ----------------------------------------------------------------------------
package pc_pkg;

    typedef enum logic [2:0] {
        NEQ    = 3'b000,
        EQ     = 3'b001,
        GT     = 3'b010,
        LT     = 3'b011,
        GTE    = 3'b100,
        LTE    = 3'b101,
        OVFL   = 3'b110,
        UNCOND = 3'b111
    } cond_e;

    localparam int FLAG_N = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_Z = 0;

    // Returns 1 when the condition selected by ccode holds for flags {N,V,Z}.
    function automatic logic cond_true(input logic [2:0] ccode, input logic [2:0] flags);
        logic n;
        logic v;
        logic z;
        logic r;
        n = flags[FLAG_N];
        v = flags[FLAG_V];
        z = flags[FLAG_Z];
        r = 1'b0;
        case (cond_e'(ccode))
            NEQ:    r = ~z;
            EQ:     r = z;
            GT:     r = ~z & ~n;
            LT:     r = n;
            GTE:    r = z | (~z & ~n);
            LTE:    r = z | n;
            OVFL:   r = v;
            UNCOND: r = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/pc_ras.sv
// ----------------------------------------------------------------------------
// pc_ras
//   Return-address stack implemented as a circular buffer. ptr_q points at the
//   next free slot; top is the entry just below it. A push while full
//   overwrites the oldest entry (which is exactly the slot at ptr_q) and keeps
//   the count saturated. A pop while empty is ignored.
// Ports
//   clk, rst_n : clock, asynchronous active-low reset (empties the stack)
//   push, din  : push din this cycle (push has priority over pop)
//   pop        : discard the top entry
//   top        : current top-of-stack value (undefined while empty)
//   empty/full : occupancy status
// ----------------------------------------------------------------------------
module pc_ras
    import pc_pkg::*;
#(
    parameter int RAS_DEPTH = 4,
    parameter int PC_W      = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] din,
    output logic [PC_W-1:0] top,
    output logic            empty,
    output logic            full
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PC_W-1:0]  mem_q [RAS_DEPTH];
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CNT_W'(RAS_DEPTH));
    assign top   = mem_q[ptr_q - PTR_W'(1)];

    // NOTE: every variable gets its default before any branch so that no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (push) begin
            ptr_d = ptr_q + PTR_W'(1);
            if (!full) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (pop && !empty) begin
            ptr_d = ptr_q - PTR_W'(1);
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments so all
    // flops sample their inputs from the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; emptiness is tracked
    // by cnt_q alone, so entry contents are never observed before a write.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[ptr_q] <= din;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// ----------------------------------------------------------------------------
// pc_sequencer
//   Registered fetch-PC generator. Evaluates branch conditions against the
//   {N,V,Z} flags, selects PC-relative or register targets, handles CALL/RET
//   through a return-address stack, and supports fetch stall and sticky halt.
// Ports
//   clk, rst_n      : clock, asynchronous active-low reset
//   stall           : hold pc, RAS and halt state this cycle
//   hlt             : halt decoded; pc freezes and halted sets next edge
//   br, breg        : branch decoded / target comes from reg_target
//   call, ret       : push pc+2 and jump / pop and jump to popped address
//   ccode, flags    : condition code and {N,V,Z}
//   imm, reg_target : signed word offset / register target
//   pc              : current fetch PC (registered)
//   pc_next         : value pc loads at the next edge (combinational)
//   taken           : redirect this cycle (combinational)
//   halted          : sticky halt status (registered)
//   ras_err         : one-cycle pulse on RAS overflow, underflow or call+ret
// ----------------------------------------------------------------------------
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int              PC_W      = 16,
    parameter int              IMM_W     = 9,
    parameter int              RAS_DEPTH = 4,
    parameter logic [PC_W-1:0] RESET_PC  = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             hlt,
    input  logic             br,
    input  logic             breg,
    input  logic             call,
    input  logic             ret,
    input  logic [2:0]       ccode,
    input  logic [2:0]       flags,
    input  logic [IMM_W-1:0] imm,
    input  logic [PC_W-1:0]  reg_target,
    output logic [PC_W-1:0]  pc,
    output logic [PC_W-1:0]  pc_next,
    output logic             taken,
    output logic             halted,
    output logic             ras_err
);

    logic [PC_W-1:0] pc_q, pc_d;
    logic            halted_q, halted_d;
    logic            ras_err_q, ras_err_d;

    logic [PC_W-1:0] seq, rel, target, imm_ext;
    logic            br_taken;
    logic            ras_push, ras_pop, ras_empty, ras_full;
    logic [PC_W-1:0] ras_top;

    pc_ras #(
        .RAS_DEPTH (RAS_DEPTH),
        .PC_W      (PC_W)
    ) u_ras (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (ras_push),
        .pop   (ras_pop),
        .din   (seq),
        .top   (ras_top),
        .empty (ras_empty),
        .full  (ras_full)
    );

    // Signed cast before widening sign-extends the word offset; the shift
    // turns it into a byte offset. All sums wrap modulo 2^PC_W.
    assign imm_ext  = PC_W'($signed(imm));
    assign seq      = pc_q + PC_W'(2);
    assign rel      = seq + (imm_ext << 1);
    assign target   = breg ? reg_target : rel;
    assign br_taken = br & cond_true(ccode, flags);

    always_comb begin
        pc_d      = pc_q;
        halted_d  = halted_q;
        ras_err_d = 1'b0;
        ras_push  = 1'b0;
        ras_pop   = 1'b0;
        taken     = 1'b0;
        if (!stall && !halted_q) begin
            if (hlt) begin
                halted_d = 1'b1;
            end else if (call) begin
                // Call wins over a simultaneous ret; the conflict and a push
                // into a full stack are both reported.
                ras_push  = 1'b1;
                pc_d      = target;
                taken     = 1'b1;
                ras_err_d = ret | ras_full;
            end else if (ret) begin
                if (!ras_empty) begin
                    ras_pop = 1'b1;
                    pc_d    = ras_top;
                    taken   = 1'b1;
                end else begin
                    pc_d      = seq;
                    ras_err_d = 1'b1;
                end
            end else if (br_taken) begin
                pc_d  = target;
                taken = 1'b1;
            end else begin
                pc_d = seq;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= RESET_PC;
            halted_q  <= 1'b0;
            ras_err_q <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            halted_q  <= halted_d;
            ras_err_q <= ras_err_d;
        end
    end

    assign pc      = pc_q;
    assign pc_next = pc_d;
    assign halted  = halted_q;
    assign ras_err = ras_err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, hlt, br, breg, call, ret;
    logic [2:0]  ccode, flags;
    logic [8:0]  imm;
    logic [15:0] reg_target;
    logic [15:0] pc, pc_next;
    logic        taken, halted, ras_err;

    pc_sequencer #(.PC_W(16), .IMM_W(9), .RAS_DEPTH(4), .RESET_PC(16'h0000)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .hlt(hlt), .br(br), .breg(breg),
        .call(call), .ret(ret), .ccode(ccode), .flags(flags), .imm(imm),
        .reg_target(reg_target), .pc(pc), .pc_next(pc_next), .taken(taken),
        .halted(halted), .ras_err(ras_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: PC, halt flag, RAS as a queue (oldest at front).
    logic [15:0] m_pc;
    logic        m_halted;
    logic        m_err;
    logic        m_taken;
    logic [15:0] m_next;
    logic [15:0] m_ras[$];
    logic        obs_taken;
    logic [15:0] obs_next;

    function automatic logic m_cond(input logic [2:0] cc, input logic [2:0] f);
        logic n, v, z;
        n = f[2]; v = f[1]; z = f[0];
        case (cc)
            3'd0: return !z;
            3'd1: return z;
            3'd2: return !z && !n;
            3'd3: return n;
            3'd4: return z || (!z && !n);
            3'd5: return z || n;
            3'd6: return v;
            default: return 1'b1;
        endcase
    endfunction

    // Applies one cycle of inputs (starting at a negedge), samples the
    // combinational outputs, advances the model and ends at the next negedge.
    task automatic drive(input logic s, input logic h, input logic b, input logic bg,
                         input logic c, input logic r, input logic [2:0] cc,
                         input logic [2:0] f, input logic [8:0] im, input logic [15:0] rt);
        logic [15:0] seq_v, tgt_v;
        stall = s; hlt = h; br = b; breg = bg; call = c; ret = r;
        ccode = cc; flags = f; imm = im; reg_target = rt;
        #1;
        obs_taken = taken;
        obs_next  = pc_next;
        seq_v = m_pc + 16'd2;
        tgt_v = bg ? rt : 16'(int'(m_pc) + 2 + 2 * int'($signed(im)));
        m_err = 1'b0; m_taken = 1'b0; m_next = m_pc;
        if (!s && !m_halted) begin
            if (h) begin
                m_halted = 1'b1;
            end else if (c) begin
                m_taken = 1'b1;
                m_next  = tgt_v;
                if (m_ras.size() == 4) begin
                    m_ras.delete(0);
                    m_err = 1'b1;
                end
                m_ras.push_back(seq_v);
                if (r) m_err = 1'b1;
            end else if (r) begin
                if (m_ras.size() > 0) begin
                    m_next  = m_ras.pop_back();
                    m_taken = 1'b1;
                end else begin
                    m_next = seq_v;
                    m_err  = 1'b1;
                end
            end else if (b && m_cond(cc, f)) begin
                m_next  = tgt_v;
                m_taken = 1'b1;
            end else begin
                m_next = seq_v;
            end
        end
        @(posedge clk);
        m_pc = m_next;
        @(negedge clk);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 3'd0, 3'd0, 9'd0, 16'd0);
    endtask

    task automatic set_pc(input logic [15:0] v);
        drive(0, 0, 1, 1, 0, 0, 3'd7, 3'd0, 9'd0, v);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        stall = 0; hlt = 0; br = 0; breg = 0; call = 0; ret = 0;
        ccode = 0; flags = 0; imm = 0; reg_target = 0;
        @(negedge clk);
        m_pc = 16'h0000; m_halted = 1'b0; m_err = 1'b0;
        m_ras.delete();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        stall = 0; hlt = 0; br = 0; breg = 0; call = 0; ret = 0;
        ccode = 0; flags = 0; imm = 0; reg_target = 0;
        #12;
        n_cmp++;
        if ({pc, halted, ras_err, taken} !== {16'h0000, 3'b000}) begin
            n_bad++;
            $display("FAIL reset_state: got pc=%h halted=%b ras_err=%b taken=%b, want 0000/0/0/0",
                     pc, halted, ras_err, taken);
        end
        @(negedge clk);
        m_pc = 16'h0000; m_halted = 1'b0; m_err = 1'b0; m_ras.delete();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            idle();
            n_cmp++;
            if ({pc, halted, obs_taken} !== {16'(2 * (i + 1)), 2'b00}) begin
                n_bad++;
                $display("FAIL idle_seq[%0d]: got pc=%h halted=%b taken=%b, want %h/0/0",
                         i, pc, halted, obs_taken, 16'(2 * (i + 1)));
            end
        end
    endtask

    task automatic test_cond();
        for (int cc = 0; cc < 8; cc++) begin
            for (int f = 0; f < 8; f++) begin
                drive(0, 0, 1, 0, 0, 0, 3'(cc), 3'(f), 9'($urandom), 16'd0);
                n_cmp++;
                if (obs_taken !== m_taken || pc !== m_pc) begin
                    n_bad++;
                    $display("FAIL cond cc=%0d f=%0d: got taken=%b pc=%h, want %b/%h",
                             cc, f, obs_taken, pc, m_taken, m_pc);
                end
            end
            drive(0, 0, 0, 0, 0, 0, 3'(cc), 3'd7, 9'd5, 16'd0);
            n_cmp++;
            if (obs_taken !== 1'b0 || pc !== m_pc) begin
                n_bad++;
                $display("FAIL cond_no_br cc=%0d: got taken=%b pc=%h, want 0/%h", cc, obs_taken, pc, m_pc);
            end
        end
    endtask

    task automatic test_branch();
        set_pc(16'h0010);
        drive(0, 0, 1, 0, 0, 0, 3'd1, 3'b001, 9'h1FE, 16'd0);
        n_cmp++;
        if (pc !== 16'h000E || obs_taken !== 1'b1) begin
            n_bad++;
            $display("FAIL beq_taken: got pc=%h taken=%b, want 000e/1", pc, obs_taken);
        end
        set_pc(16'h0010);
        drive(0, 0, 1, 0, 0, 0, 3'd1, 3'b000, 9'h1FE, 16'd0);
        n_cmp++;
        if (pc !== 16'h0012 || obs_taken !== 1'b0) begin
            n_bad++;
            $display("FAIL beq_not_taken: got pc=%h taken=%b, want 0012/0", pc, obs_taken);
        end
    endtask

    task automatic test_call_ret();
        apply_reset();
        set_pc(16'h0100);
        drive(0, 0, 0, 0, 1, 0, 3'd0, 3'd0, 9'h020, 16'd0);
        n_cmp++;
        if (pc !== 16'h0142 || obs_taken !== 1'b1 || ras_err !== 1'b0) begin
            n_bad++;
            $display("FAIL call: got pc=%h taken=%b err=%b, want 0142/1/0", pc, obs_taken, ras_err);
        end
        drive(0, 0, 0, 0, 0, 1, 3'd0, 3'd0, 9'd0, 16'd0);
        n_cmp++;
        if (pc !== 16'h0102 || obs_taken !== 1'b1 || ras_err !== 1'b0) begin
            n_bad++;
            $display("FAIL ret: got pc=%h taken=%b err=%b, want 0102/1/0", pc, obs_taken, ras_err);
        end
        drive(0, 0, 0, 0, 0, 1, 3'd0, 3'd0, 9'd0, 16'd0);
        n_cmp++;
        if (pc !== 16'h0104 || obs_taken !== 1'b0 || ras_err !== 1'b1) begin
            n_bad++;
            $display("FAIL ret_empty: got pc=%h taken=%b err=%b, want 0104/0/1", pc, obs_taken, ras_err);
        end
        idle();
        n_cmp++;
        if (ras_err !== 1'b0) begin
            n_bad++;
            $display("FAIL ras_err_pulse: got %b, want 0", ras_err);
        end
        drive(0, 0, 0, 1, 1, 1, 3'd0, 3'd0, 9'd0, 16'h0700);
        n_cmp++;
        if (pc !== 16'h0700 || ras_err !== 1'b1) begin
            n_bad++;
            $display("FAIL call_ret_conflict: got pc=%h err=%b, want 0700/1", pc, ras_err);
        end
    endtask

    task automatic test_ras_overflow();
        logic [15:0] want_ret [4];
        want_ret = '{16'h1302, 16'h1202, 16'h1102, 16'h1002};
        apply_reset();
        set_pc(16'h0200);
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 1, 1, 0, 3'd0, 3'd0, 9'd0, 16'(16'h1000 + i * 16'h0100));
            n_cmp++;
            if (ras_err !== (i == 4)) begin
                n_bad++;
                $display("FAIL overflow_call[%0d]: got err=%b, want %b", i, ras_err, (i == 4));
            end
        end
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 0, 1, 3'd0, 3'd0, 9'd0, 16'd0);
            n_cmp++;
            if (pc !== want_ret[i] || ras_err !== 1'b0) begin
                n_bad++;
                $display("FAIL overflow_ret[%0d]: got pc=%h err=%b, want %h/0", i, pc, ras_err, want_ret[i]);
            end
        end
        drive(0, 0, 0, 0, 0, 1, 3'd0, 3'd0, 9'd0, 16'd0);
        n_cmp++;
        if (pc !== 16'h1004 || ras_err !== 1'b1) begin
            n_bad++;
            $display("FAIL underflow_ret: got pc=%h err=%b, want 1004/1", pc, ras_err);
        end
    endtask

    task automatic test_stall();
        apply_reset();
        set_pc(16'h0040);
        drive(0, 0, 0, 1, 1, 0, 3'd0, 3'd0, 9'd0, 16'h0300);
        for (int i = 0; i < 3; i++) begin
            drive(1, (i == 1), 1, 1, (i == 2), (i == 0), 3'd7, 3'd0, 9'd0, 16'h0500);
            n_cmp++;
            if ({pc, obs_next, obs_taken, ras_err, halted} !== {16'h0300, 16'h0300, 3'b000}) begin
                n_bad++;
                $display("FAIL stall[%0d]: got pc=%h next=%h taken=%b err=%b halted=%b, want 0300/0300/0/0/0",
                         i, pc, obs_next, obs_taken, ras_err, halted);
            end
        end
        drive(0, 0, 1, 1, 0, 0, 3'd7, 3'd0, 9'd0, 16'h0500);
        n_cmp++;
        if (pc !== 16'h0500 || obs_taken !== 1'b1) begin
            n_bad++;
            $display("FAIL unstall_branch: got pc=%h taken=%b, want 0500/1", pc, obs_taken);
        end
        drive(0, 0, 0, 0, 0, 1, 3'd0, 3'd0, 9'd0, 16'd0);
        n_cmp++;
        if (pc !== 16'h0042) begin
            n_bad++;
            $display("FAIL stall_ras_kept: got pc=%h, want 0042", pc);
        end
    endtask

    task automatic test_halt();
        set_pc(16'h0020);
        drive(0, 1, 1, 1, 0, 0, 3'd7, 3'd0, 9'd0, 16'h0900);
        n_cmp++;
        if ({pc, obs_next, obs_taken, halted} !== {16'h0020, 16'h0020, 2'b01}) begin
            n_bad++;
            $display("FAIL hlt: got pc=%h next=%h taken=%b halted=%b, want 0020/0020/0/1",
                     pc, obs_next, obs_taken, halted);
        end
        for (int i = 0; i < 10; i++) begin
            drive(0, 1'($urandom), 1, 1'($urandom), 1'($urandom), 1'($urandom),
                  3'd7, 3'($urandom), 9'($urandom), 16'($urandom));
            n_cmp++;
            if ({pc, halted, obs_taken, ras_err} !== {16'h0020, 3'b100}) begin
                n_bad++;
                $display("FAIL halted_hold[%0d]: got pc=%h halted=%b taken=%b err=%b, want 0020/1/0/0",
                         i, pc, halted, obs_taken, ras_err);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (pc !== 16'h0000 || halted !== 1'b0) begin
            n_bad++;
            $display("FAIL async_reset: got pc=%h halted=%b, want 0000/0", pc, halted);
        end
        @(negedge clk);
        m_pc = 16'h0000; m_halted = 1'b0; m_err = 1'b0; m_ras.delete();
        rst_n = 1'b1;
        idle();
        n_cmp++;
        if (pc !== 16'h0002) begin
            n_bad++;
            $display("FAIL post_reset_fetch: got pc=%h, want 0002", pc);
        end
    endtask

    task automatic test_wrap();
        set_pc(16'hFFFE);
        idle();
        n_cmp++;
        if (pc !== 16'h0000) begin
            n_bad++;
            $display("FAIL pc_wrap: got pc=%h, want 0000", pc);
        end
        drive(0, 0, 1, 1, 0, 0, 3'd7, 3'd0, 9'd0, 16'h1234);
        n_cmp++;
        if (pc !== 16'h1234 || obs_taken !== 1'b1) begin
            n_bad++;
            $display("FAIL breg_uncond: got pc=%h taken=%b, want 1234/1", pc, obs_taken);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 500; i++) begin
            if (m_halted && $urandom_range(0, 3) == 0) apply_reset();
            drive(($urandom_range(0, 7) == 0), ($urandom_range(0, 40) == 0), 1'($urandom),
                  1'($urandom), ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0),
                  3'($urandom), 3'($urandom), 9'($urandom), 16'($urandom));
            n_cmp++;
            if ({pc, obs_next, obs_taken, halted, ras_err} !== {m_pc, m_next, m_taken, m_halted, m_err}) begin
                n_bad++;
                $display("FAIL random[%0d]: got pc=%h next=%h taken=%b halted=%b err=%b, want %h/%h/%b/%b/%b",
                         i, pc, obs_next, obs_taken, halted, ras_err, m_pc, m_next, m_taken, m_halted, m_err);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_cond();
        test_branch();
        test_call_ret();
        test_ras_overflow();
        test_stall();
        test_halt();
        test_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
